// File: rtl/wgt_pkg.sv
// Shared definitions for the weight streaming path.
//   WGT_DATA_WIDTH : width of one weight word on AXIS and on the parser side
//   PARSER_GROUP   : words the parser consumes as one group (prefill depth)
//   state_t        : job sequencer states
package wgt_pkg;

    localparam int WGT_DATA_WIDTH = 512;
    localparam int PARSER_GROUP   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/wgt_fwft_fifo.sv
// First-word-fall-through FIFO built from a register array.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous pointer/level clear (discards contents)
//   push, din  : write din at the tail (caller guarantees not full)
//   pop        : drop the head (caller guarantees not empty)
//   dout       : head word, combinational from storage
//   level      : occupancy, one bit wider than the pointers so full != empty
module wgt_fwft_fifo
    import wgt_pkg::*;
#(
    parameter int DATA_WIDTH = WGT_DATA_WIDTH,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    // NOTE: the storage array is reset on purpose so the head word reads as
    // zero out of reset; a write during clear is dropped with the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      level <= level + LW'(1);
            else if (pop && !push) level <= level - LW'(1);
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/wgt_stream_buffer.sv
// Weight stream buffer: AXIS slave into a FWFT FIFO, head word presented to
// the parser on fm_out, popped on input_req. Sequences one job at a time:
// prefill, one-cycle start_conv_pulse, run until num_words popped, done pulse.
//   start, num_words       : job request (sampled in IDLE only)
//   s_tdata/tvalid/tlast   : AXIS weight beats; s_tready back-pressure
//   input_req, fm_out      : parser pop request and zero-latency head word
//   start_conv_pulse, done : one-cycle job milestones; busy high in FILL/RUN
//   underrun_err           : sticky, pop requested while FIFO empty
//   tlast_err              : sticky, s_tlast disagrees with the job count
//   level                  : FIFO occupancy
module wgt_stream_buffer
    import wgt_pkg::*;
#(
    parameter int DATA_WIDTH = WGT_DATA_WIDTH,
    parameter int DEPTH      = 8,
    parameter int PREFILL    = PARSER_GROUP,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_WIDTH-1:0]    num_words,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    output logic                    s_tready,
    input  logic                    input_req,
    output logic [DATA_WIDTH-1:0]   fm_out,
    output logic                    start_conv_pulse,
    output logic                    busy,
    output logic                    done,
    output logic                    underrun_err,
    output logic                    tlast_err,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0]        FULL_LEVEL  = LW'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] PREFILL_CNT = CNT_WIDTH'(PREFILL);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] num_words_q;
    logic [CNT_WIDTH-1:0] rx_cnt;
    logic [CNT_WIDTH-1:0] tx_cnt;
    logic [CNT_WIDTH-1:0] prefill_thr;
    logic                 start_acc;
    logic                 push;
    logic                 pop;
    logic                 underrun;
    logic                 prefill_met;
    logic                 rx_last;
    logic                 last_pop;

    assign busy      = (state != IDLE);
    assign start_acc = (state == IDLE) && start;

    // Ready depends only on registered state, so a pop in the same cycle as
    // a full FIFO does not open the slot until the next cycle.
    assign s_tready = busy && (level < FULL_LEVEL) && (rx_cnt < num_words_q);
    assign push     = s_tvalid && s_tready;

    // No bypass: an empty FIFO never pops, even if a beat is being pushed.
    assign pop      = (state == RUN) && input_req && (level != '0);
    assign underrun = (state == RUN) && input_req && (level == '0);

    // Short jobs start the parser once every word they have is buffered.
    assign prefill_thr = (num_words_q < PREFILL_CNT) ? num_words_q : PREFILL_CNT;
    assign prefill_met = (state == FILL) && (CNT_WIDTH'(level) >= prefill_thr);

    assign rx_last  = (rx_cnt + CNT_ONE == num_words_q);
    assign last_pop = pop && (tx_cnt + CNT_ONE == num_words_q);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: next state defaults to the current state before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && (num_words != '0)) state_nxt = FILL;
            FILL:    if (prefill_met)                state_nxt = RUN;
            RUN:     if (last_pop)                   state_nxt = IDLE;
            default:                                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_words_q      <= '0;
            rx_cnt           <= '0;
            tx_cnt           <= '0;
            underrun_err     <= 1'b0;
            tlast_err        <= 1'b0;
            start_conv_pulse <= 1'b0;
            done             <= 1'b0;
        end else begin
            // FILL is left exactly once per job, so the pulse cannot repeat.
            start_conv_pulse <= prefill_met;
            done             <= (start_acc && (num_words == '0)) || last_pop;
            if (start_acc) begin
                num_words_q  <= num_words;
                rx_cnt       <= '0;
                tx_cnt       <= '0;
                underrun_err <= 1'b0;
                tlast_err    <= 1'b0;
            end else begin
                if (push) begin
                    rx_cnt <= rx_cnt + CNT_ONE;
                    if (s_tlast != rx_last) tlast_err <= 1'b1;
                end
                if (pop)      tx_cnt       <= tx_cnt + CNT_ONE;
                if (underrun) underrun_err <= 1'b1;
            end
        end
    end

    wgt_fwft_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_acc),
        .push  (push),
        .din   (s_tdata),
        .pop   (pop),
        .dout  (fm_out),
        .level (level)
    );

endmodule

// File: tb/tb_wgt_stream_buffer.sv
// Directed self-checking bench for wgt_stream_buffer. A cycle driver plays
// an AXIS source and a parser model; each test task checks its own results.
module tb_wgt_stream_buffer;

    localparam int DW    = 512;
    localparam int DEPTH = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [15:0]    num_words;
    logic [DW-1:0]  s_tdata;
    logic           s_tvalid;
    logic           s_tlast;
    logic           s_tready;
    logic           input_req;
    logic [DW-1:0]  fm_out;
    logic           start_conv_pulse;
    logic           busy;
    logic           done;
    logic           underrun_err;
    logic           tlast_err;
    logic [3:0]     level;

    int errors = 0;
    int checks = 0;

    // Per-job observations gathered by run_job.
    int job_id, sent, popped, req_used, prev_level;
    int pulse_cnt, pulse_prev_level, done_cnt, level_at_done;
    int tready_at_full, full_seen, max_level, underrun_obs, tlast_first_sent;
    bit run_seen, busy_at_done;
    logic [DW-1:0] got[$];

    wgt_stream_buffer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .num_words        (num_words),
        .s_tdata          (s_tdata),
        .s_tvalid         (s_tvalid),
        .s_tlast          (s_tlast),
        .s_tready         (s_tready),
        .input_req        (input_req),
        .fm_out           (fm_out),
        .start_conv_pulse (start_conv_pulse),
        .busy             (busy),
        .done             (done),
        .underrun_err     (underrun_err),
        .tlast_err        (tlast_err),
        .level            (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(input int j, input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 ^ 32'(j * 256 + i);
        return {16{w}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic job_init(input int j);
        job_id = j; sent = 0; popped = 0; req_used = 0; prev_level = 0;
        pulse_cnt = 0; pulse_prev_level = -1; done_cnt = 0; level_at_done = -1;
        tready_at_full = 0; full_seen = 0; max_level = 0; underrun_obs = 0;
        tlast_first_sent = -1; run_seen = 0; busy_at_done = 1'b1;
        got.delete();
    endtask

    task automatic start_job(input int n);
        start = 1'b1;
        num_words = 16'(n);
        step();
        start = 1'b0;
    endtask

    // Runs the AXIS source and parser model until done, a target level, or
    // the cycle budget. Parser requests start on start_conv_pulse.
    task automatic run_job(input int n_send, input int tlast_beat,
                           input int pause_after, input int pause_cycles,
                           input int req_limit, input int stop_level,
                           input int max_cycles);
        int pause_left;
        bit acc;
        bit rq;
        pause_left = pause_cycles;
        for (int c = 0; c < max_cycles; c++) begin
            if (start_conv_pulse) begin
                pulse_cnt++;
                pulse_prev_level = prev_level;
                run_seen = 1'b1;
            end
            if (tlast_err && tlast_first_sent < 0) tlast_first_sent = sent;
            if (int'(level) > max_level) max_level = int'(level);
            if (int'(level) == DEPTH) begin
                full_seen = 1;
                if (s_tready) tready_at_full++;
            end
            if (done) begin
                done_cnt++;
                busy_at_done = busy;
                level_at_done = int'(level);
                break;
            end
            if (stop_level >= 0 && int'(level) == stop_level) break;
            prev_level = int'(level);

            if (sent < n_send) begin
                s_tvalid = 1'b1;
                s_tdata  = word(job_id, sent);
                s_tlast  = (sent + 1 == tlast_beat);
            end else begin
                s_tvalid = 1'b0;
                s_tdata  = '0;
                s_tlast  = 1'b0;
            end
            acc = s_tvalid && s_tready;

            rq = run_seen && (req_used < req_limit);
            if (rq && popped == pause_after && pause_left > 0) begin
                rq = 1'b0;
                pause_left--;
            end
            input_req = rq;
            if (rq) begin
                req_used++;
                if (level != 4'd0) begin
                    got.push_back(fm_out);
                    popped++;
                end else begin
                    underrun_obs++;
                end
            end
            step();
            if (acc) sent++;
        end
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        input_req = 1'b0;
    endtask

    task automatic check_words(input string name, input int n);
        checks++;
        if (got.size() != n) begin
            errors++;
            $display("FAIL %s_count: got %0d words, want %0d", name, got.size(), n);
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== word(job_id, i)) begin
                errors++;
                $display("FAIL %s_word%0d: got %h want %h", name, i, got[i], word(job_id, i));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", s_tready); end
        checks++; if (fm_out !== '0) begin errors++; $display("FAIL reset_fm_out: got %h want 0", fm_out); end
        checks++; if (start_conv_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", start_conv_pulse); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (underrun_err !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun_err); end
        checks++; if (tlast_err !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", tlast_err); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        rst_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0 || s_tready !== 1'b0) begin errors++; $display("FAIL post_reset_idle: busy=%b tready=%b want 0 0", busy, s_tready); end
    endtask

    task automatic test_basic();
        job_init(1);
        start_job(6);
        run_job(6, 6, -1, 0, 1000, -1, 100);
        checks++; if (pulse_cnt != 1) begin errors++; $display("FAIL basic_pulse_cnt: got %0d want 1", pulse_cnt); end
        checks++; if (pulse_prev_level != 3) begin errors++; $display("FAIL basic_pulse_level: level before pulse %0d want 3", pulse_prev_level); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done: got %0d want 1", done_cnt); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); end
        checks++; if (level_at_done != 0) begin errors++; $display("FAIL basic_level_at_done: got %0d want 0", level_at_done); end
        checks++; if (tlast_err !== 1'b0 || underrun_err !== 1'b0) begin errors++; $display("FAIL basic_errs: tlast=%b underrun=%b want 0 0", tlast_err, underrun_err); end
        check_words("basic", 6);
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", done); end
    endtask

    task automatic test_backpressure();
        job_init(2);
        start_job(12);
        run_job(12, 12, 3, 12, 1000, -1, 200);
        checks++; if (full_seen != 1 || max_level != DEPTH) begin errors++; $display("FAIL bp_full: seen=%0d max=%0d want 1 8", full_seen, max_level); end
        checks++; if (tready_at_full != 0) begin errors++; $display("FAIL bp_tready_full: %0d cycles ready at level 8, want 0", tready_at_full); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
        checks++; if (tlast_err !== 1'b0) begin errors++; $display("FAIL bp_tlast: got %b want 0", tlast_err); end
        check_words("bp", 12);
    endtask

    task automatic test_underrun();
        job_init(3);
        start_job(6);
        run_job(3, 6, -1, 0, 4, -1, 20);
        check_words("ur_first", 3);
        checks++; if (underrun_err !== 1'b1) begin errors++; $display("FAIL ur_flag: got %b want 1", underrun_err); end
        checks++; if (done_cnt != 0 || busy !== 1'b1) begin errors++; $display("FAIL ur_still_running: done=%0d busy=%b want 0 1", done_cnt, busy); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL ur_level: got %0d want 0", level); end
        // Finishing the job shows tx_cnt held at 3 through the underrun.
        run_job(6, 6, -1, 0, 1000, -1, 50);
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ur_done: got %0d want 1", done_cnt); end
        check_words("ur_all", 6);
        checks++; if (underrun_err !== 1'b1) begin errors++; $display("FAIL ur_sticky: got %b want 1", underrun_err); end
    endtask

    task automatic test_tlast();
        job_init(4);
        start_job(4);
        checks++; if (underrun_err !== 1'b0) begin errors++; $display("FAIL tl_err_cleared: underrun=%b want 0", underrun_err); end
        run_job(4, 2, -1, 0, 1000, -1, 60);
        checks++; if (tlast_first_sent != 2) begin errors++; $display("FAIL tl_flag_time: seen after beat %0d want 2", tlast_first_sent); end
        checks++; if (tlast_err !== 1'b1) begin errors++; $display("FAIL tl_flag: got %b want 1", tlast_err); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL tl_done: got %0d want 1", done_cnt); end
        check_words("tl", 4);
    endtask

    task automatic test_zero_len();
        int bad_ready;
        int bad_pulse;
        bad_ready = 0;
        bad_pulse = 0;
        s_tvalid = 1'b1;
        s_tdata  = word(5, 0);
        start_job(0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
        for (int i = 0; i < 5; i++) begin
            if (s_tready !== 1'b0) bad_ready++;
            if (start_conv_pulse !== 1'b0) bad_pulse++;
            step();
            if (i == 0) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b want 0", done); end
            end
        end
        s_tvalid = 1'b0;
        checks++; if (bad_ready != 0) begin errors++; $display("FAIL zero_tready: high %0d cycles want 0", bad_ready); end
        checks++; if (bad_pulse != 0) begin errors++; $display("FAIL zero_pulse: high %0d cycles want 0", bad_pulse); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL zero_level: got %0d want 0", level); end
    endtask

    task automatic test_two_words();
        job_init(6);
        start_job(2);
        run_job(2, 2, -1, 0, 1000, -1, 40);
        checks++; if (pulse_cnt != 1 || pulse_prev_level != 2) begin errors++; $display("FAIL two_pulse: cnt=%0d level=%0d want 1 2", pulse_cnt, pulse_prev_level); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL two_done: got %0d want 1", done_cnt); end
        check_words("two", 2);
    endtask

    task automatic test_reset_mid_run();
        job_init(7);
        start_job(12);
        run_job(12, 12, 0, 1000, 1000, 5, 40);
        checks++; if (level !== 4'd5 || busy !== 1'b1) begin errors++; $display("FAIL rst_pre: level=%0d busy=%b want 5 1", level, busy); end
        s_tvalid = 1'b1;
        rst_n = 1'b0;
        #2;
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", s_tready); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", level); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (fm_out !== '0 || start_conv_pulse !== 1'b0) begin errors++; $display("FAIL rst_outputs: fm_out=%h pulse=%b want 0 0", fm_out, start_conv_pulse); end
        s_tvalid = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        job_init(8);
        start_job(3);
        run_job(3, 3, -1, 0, 1000, -1, 40);
        checks++; if (pulse_cnt != 1 || done_cnt != 1) begin errors++; $display("FAIL rst_newjob: pulse=%0d done=%0d want 1 1", pulse_cnt, done_cnt); end
        checks++; if (tlast_err !== 1'b0 || underrun_err !== 1'b0) begin errors++; $display("FAIL rst_newjob_errs: tlast=%b underrun=%b want 0 0", tlast_err, underrun_err); end
        check_words("rst_newjob", 3);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        num_words = '0;
        s_tdata   = '0;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        input_req = 1'b0;

        test_reset();
        test_basic();
        test_backpressure();
        test_underrun();
        test_tlast();
        test_zero_len();
        test_two_words();
        test_reset_mid_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wgt_stream_buffer.md
Name: wgt_stream_buffer

Overview:
Upstream feeder for the weight parser. Accepts 512-bit weight words from an AXI-Stream slave port and holds them in a first-word-fall-through FIFO. Presents the head word combinationally on fm_out and pops it on each input_req cycle. Sequences a conv job: prefill, a one-cycle start_conv_pulse, run until num_words are consumed, then a done pulse.

Parameters:
DATA_WIDTH, 512, AXIS and fm_out word width
DEPTH, 8, FIFO depth in words (power of 2, >= PREFILL+1)
PREFILL, 3, words buffered before start_conv_pulse (one parser group)
CNT_WIDTH, 16, width of the job word counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job start request, sampled in IDLE only
num_words  in  CNT_WIDTH  words in this job, latched on accepted start
s_tdata  in  DATA_WIDTH  AXIS weight data
s_tvalid  in  1  AXIS valid
s_tlast  in  1  AXIS last beat of job
s_tready  out  1  AXIS ready
input_req  in  1  parser pop request; consumes fm_out this cycle
fm_out  out  DATA_WIDTH  FIFO head word (combinational from storage)
start_conv_pulse  out  1  one-cycle pulse to parser when prefill is met
busy  out  1  high in FILL/RUN
done  out  1  one-cycle pulse when the last word is popped
underrun_err  out  1  sticky: input_req while FIFO empty
tlast_err  out  1  sticky: s_tlast mismatch with the job count
level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values: s_tready=0, fm_out=0 (storage cleared), start_conv_pulse=0, busy=0, done=0, underrun_err=0, tlast_err=0, level=0. State=IDLE. All counters are 0.
- States: IDLE, FILL, RUN.
- IDLE -> FILL on start=1.
  - Latch num_words. Clear rx_cnt, tx_cnt, both error flags and the FIFO pointers.
  - If num_words==0: stay in IDLE and pulse done on the next cycle. No start_conv_pulse.
- s_tready = (state is FILL or RUN) && level<DEPTH && rx_cnt<num_words_q.
- Push occurs when s_tvalid && s_tready; rx_cnt increments.
- tlast_err is set if:
  - s_tlast=1 on a push where rx_cnt+1 != num_words_q, or
  - s_tlast=0 on the push where rx_cnt+1 == num_words_q.
- FILL -> RUN when level >= min(PREFILL, num_words_q). start_conv_pulse is high exactly one cycle, the cycle after the condition is registered. It is never re-issued within a job.
- RUN, pop: input_req && level>0 pops the head and increments tx_cnt.
- RUN, underrun: input_req && level==0 sets underrun_err. Pointers are unchanged and fm_out shows the stale head slot.
- input_req in IDLE or FILL is ignored; no pop, no error.
- The parser latches fm_out in the same cycle input_req is high, so fm_out must be the head word with zero latency (FWFT).
- Simultaneous push and pop:
  - Both occur; level is unchanged.
  - With level==0, pop is not allowed (no bypass), so underrun_err is set.
  - At level==DEPTH, pop is allowed; push is blocked by s_tready=0 (registered-level rule).
- RUN -> IDLE on the pop that makes tx_cnt==num_words_q. done pulses for 1 cycle in the following cycle and busy falls at the same time.
- FIFO contents are discarded at the next start.
- start while busy is ignored.
- Asynchronous reset mid-job returns to the reset values immediately. Any in-flight AXIS beat is dropped (s_tready=0).
- Pointers wrap modulo DEPTH. level is tracked separately so full and empty are distinguishable.

Decomposition:
- Shared package wgt_pkg: DATA_WIDTH=512, the parser group size (3 words), state encoding constants (IDLE/FILL/RUN).
- One sub-module, wgt_fwft_fifo:
  - Parameters DATA_WIDTH, DEPTH.
  - Ports clk, rst_n, push, din, pop, dout, level.
  - Register-array storage with combinational read of the head.
- The top module holds the FSM, counters and error logic.

Test Plan:
- Basic job: num_words=6, AXIS streams 6 beats back-to-back with tlast on beat 6.
  - start_conv_pulse fires once, the cycle after level reaches 3.
  - Parser-model pops return words 0..5 in order.
  - done pulses after the 6th pop; both error flags stay 0.
- Backpressure: num_words=12, no pops after the first 3.
  - s_tready drops when level==8.
  - After the pops resume, all 12 words are delivered in order with none lost or duplicated.
- Underrun: num_words=6, only 3 words sent, input_req held for 4 cycles.
  - The first 3 pops return words 0..2.
  - The 4th cycle sets underrun_err and tx_cnt stays 3.
- tlast mismatch: num_words=4 with tlast on beat 2 -> tlast_err=1 after beat 2. The remaining beats are still accepted, and done pulses after 4 pops.
- Edge lengths:
  - num_words=0 -> done pulses 1 cycle after start, no start_conv_pulse, s_tready stays 0.
  - num_words=2 -> start_conv_pulse fires at level=2.
- Reset mid-RUN: assert rst_n=0 with level=5.
  - Immediately: s_tready=0, level=0, busy=0.
  - A new job with num_words=3 then completes normally.
